// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam int          INSTR_W      = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    DELIV = 2'd2
  } fetch_state_e;

  // Which source the next-pc mux selected; anything but SEL_SEQ is a redirect.
  typedef enum logic [1:0] {
    SEL_SEQ,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_FLUSH
  } pc_src_e;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/ack bus between the fetch controller and memory.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-pc priority mux (flush > branch > jump > pc+4) with
// word alignment of redirect targets.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_target,
  input  logic              bj_en,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              j_taken,
  input  logic [ADDR_W-1:0] j_target,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misaligned
);

  pc_src_e           src;
  logic [ADDR_W-1:0] raw;

  // NOTE: every output of a combinational block gets a default first so no
  // path through the if-chain leaves a value unassigned (which infers a latch).
  always_comb begin
    src = SEL_SEQ;
    raw = pc_plus4;
    if (flush) begin
      src = SEL_FLUSH;
      raw = flush_target;
    end else if (bj_en && br_taken) begin
      src = SEL_BRANCH;
      raw = br_target;
    end else if (bj_en && j_taken) begin
      src = SEL_JUMP;
      raw = j_target;
    end
  end

  // pc+4 from an aligned pc is always aligned, so only redirects can fault.
  assign misaligned = (src != SEL_SEQ) && is_misaligned(raw[1:0]);
  assign next_pc    = {raw[ADDR_W-1:2], 2'b00};

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: BOOT -> REQ -> DELIV loop with stall, branch,
// jump and flush redirects, including dropping a request that a flush overtook.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          ADDR_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  flush_target,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               j_taken,
  input  logic [ADDR_W-1:0]  j_target,
  fetch_if.master            imem,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  pc_plus4,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               addr_err,
  output logic [31:0]        fetch_cnt
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

  fetch_state_e      state;
  logic              req_q;
  logic [ADDR_W-1:0] req_addr;
  logic              drop;
  logic [ADDR_W-1:0] next_pc;
  logic              next_misaligned;
  logic              bj_en;

  assign pc_plus4       = pc + ADDR_W'(4);
  assign bj_en          = (state == DELIV) && !stall;
  assign imem.imem_req  = req_q;
  // Separate from pc so an overtaken request keeps its address until acked.
  assign imem.imem_addr = req_addr;

  next_pc_sel #(.ADDR_W(ADDR_W)) u_next_pc_sel (
    .pc_plus4     (pc_plus4),
    .flush        (flush),
    .flush_target (flush_target),
    .bj_en        (bj_en),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .j_taken      (j_taken),
    .j_target     (j_target),
    .next_pc      (next_pc),
    .misaligned   (next_misaligned)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values; blocking here would let later lines see updated state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= PC_RST;
      req_addr    <= PC_RST;
      req_q       <= 1'b0;
      instr       <= '0;
      instr_valid <= 1'b0;
      drop        <= 1'b0;
      addr_err    <= 1'b0;
      fetch_cnt   <= '0;
    end else begin
      case (state)
        BOOT: begin
          state    <= REQ;
          req_q    <= 1'b1;
          req_addr <= pc;
        end

        REQ: begin
          if (flush) begin
            pc       <= next_pc;
            addr_err <= addr_err | next_misaligned;
            if (imem.imem_ack) begin
              // Old word arrives with the flush: discard it and re-request.
              drop     <= 1'b0;
              req_addr <= next_pc;
            end else begin
              drop <= 1'b1;
            end
          end else if (imem.imem_ack) begin
            if (drop) begin
              drop     <= 1'b0;
              req_addr <= pc;
            end else begin
              instr       <= imem.imem_rdata;
              instr_valid <= 1'b1;
              req_q       <= 1'b0;
              state       <= DELIV;
            end
          end
        end

        DELIV: begin
          // A flush redirects even under stall; only a consumed word counts.
          if (!stall || flush) begin
            pc          <= next_pc;
            req_addr    <= next_pc;
            addr_err    <= addr_err | next_misaligned;
            instr_valid <= 1'b0;
            req_q       <= 1'b1;
            state       <= REQ;
            if (!stall) fetch_cnt <= fetch_cnt + 32'd1;
          end
        end

        default: begin
          state       <= BOOT;
          req_q       <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// stall/redirect/latency traffic against a fetch-sequence reference model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, br_taken, j_taken;
  logic [31:0] flush_target, br_target, j_target;
  logic [31:0] pc, pc_plus4, instr, fetch_cnt;
  logic        instr_valid, addr_err;

  fetch_if #(.ADDR_W(32)) imem ();

  fetch_ctrl #(.RESET_PC(RST_PC), .ADDR_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .flush        (flush),
    .flush_target (flush_target),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .j_taken      (j_taken),
    .j_target     (j_target),
    .imem         (imem),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .addr_err     (addr_err),
    .fetch_cnt    (fetch_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: where the next delivered instruction must come from,
  // how many have been consumed, and whether a bad target was ever seen.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_err;

  // Memory model state.
  int          wait_left;
  int          lat_fixed;
  bit          stale;
  logic        prev_req, prev_ack;
  logic [31:0] prev_addr;
  int          idle;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  function automatic int next_lat();
    return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
  endfunction

  task automatic redirect(input logic [31:0] t);
    if (t[1:0] != 2'b00) m_err = 1'b1;
    m_pc = {t[31:2], 2'b00};
  endtask

  task automatic observe();
    check("fetch_cnt", fetch_cnt, m_cnt);
    check("addr_err", {31'd0, addr_err}, {31'd0, m_err});
    check("pc_plus4", pc_plus4, pc + 32'd4);
    if (instr_valid) begin
      check("deliv_pc", pc, m_pc);
      check("deliv_instr", instr, mem_word(m_pc));
      idle = 0;
    end else begin
      idle++;
      if (idle > 40) begin
        check("progress_timeout", idle, 40);
        idle = 0;
      end
    end
    if (prev_req && !prev_ack) begin
      check("req_hold", {31'd0, imem.imem_req}, 32'd1);
      check("addr_hold", imem.imem_addr, prev_addr);
    end
  endtask

  // One clock: drive inputs and memory response, advance model, then sample.
  task automatic tick(input bit st, input bit fl, input logic [31:0] ft,
                      input bit br, input logic [31:0] bt,
                      input bit jj, input logic [31:0] jt);
    logic iv;
    iv           = instr_valid;
    stall        = st;
    flush        = fl;
    flush_target = ft;
    br_taken     = br;
    br_target    = bt;
    j_taken      = jj;
    j_target     = jt;
    if (stale) begin
      imem.imem_ack   = 1'b1;
      imem.imem_rdata = 32'hDEAD_BEEF;
    end else if (imem.imem_req) begin
      if (wait_left == 0) begin
        imem.imem_ack   = 1'b1;
        imem.imem_rdata = mem_word(imem.imem_addr);
        wait_left       = next_lat();
      end else begin
        imem.imem_ack   = 1'b0;
        imem.imem_rdata = 32'h0;
        wait_left--;
      end
    end else begin
      imem.imem_ack   = 1'b0;
      imem.imem_rdata = 32'h0;
    end

    if (fl) begin
      if (iv && !st) m_cnt = m_cnt + 32'd1;
      redirect(ft);
    end else if (iv && !st) begin
      m_cnt = m_cnt + 32'd1;
      if (br)      redirect(bt);
      else if (jj) redirect(jt);
      else         m_pc = m_pc + 32'd4;
    end

    prev_req  = imem.imem_req;
    prev_ack  = imem.imem_ack;
    prev_addr = imem.imem_addr;
    @(posedge clk);
    #1;
    observe();
  endtask

  task automatic idle_tick();
    tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic wait_iv();
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      idle_tick();
      n++;
    end
    if (!instr_valid) check("wait_iv_timeout", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic do_reset(input int n);
    reset           = 1'b0;
    stall           = 1'b0;
    flush           = 1'b0;
    br_taken        = 1'b0;
    j_taken         = 1'b0;
    imem.imem_ack   = 1'b0;
    imem.imem_rdata = 32'h0;
    stale           = 1'b0;
    @(posedge clk);
    #1;
    check("rst_req_drop", {31'd0, imem.imem_req}, 32'd0);
    repeat (n - 1) begin
      @(posedge clk);
      #1;
    end
    m_pc      = RST_PC;
    m_cnt     = 32'd0;
    m_err     = 1'b0;
    wait_left = next_lat();
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    idle      = 0;
    check("rst_iv", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, RST_PC);
    check("rst_instr", instr, 32'd0);
    check("rst_cnt", fetch_cnt, 32'd0);
    check("rst_err", {31'd0, addr_err}, 32'd0);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_target();
    int r;
    r = int'($urandom_range(0, 39));
    if (r == 0) return 32'hFFFF_FFF8;
    if (r == 1) return $urandom;
    return 32'h0000_3000 + ($urandom_range(0, 4095) << 2);
  endfunction

  initial begin
    logic [31:0] hold_pc, hold_instr, hold_cnt;
    int          n;

    flush_target = 32'h0;
    br_target    = 32'h0;
    j_target     = 32'h0;
    lat_fixed    = 0;
    do_reset(3);

    // Zero-wait memory: 0x3000, 0x3004, 0x3008 back to back.
    idle_tick();
    check("boot_req", {31'd0, imem.imem_req}, 32'd1);
    check("boot_addr", imem.imem_addr, 32'h0000_3000);
    check("boot_iv", {31'd0, instr_valid}, 32'd0);
    idle_tick();
    check("first_iv", {31'd0, instr_valid}, 32'd1);
    check("first_pc", pc, 32'h0000_3000);
    idle_tick();
    check("second_addr", imem.imem_addr, 32'h0000_3004);
    lat_fixed = 3;
    idle_tick();
    check("second_pc", pc, 32'h0000_3004);
    idle_tick();
    check("third_addr", imem.imem_addr, 32'h0000_3008);

    // Slow memory, then four stalled cycles in DELIV.
    wait_iv();
    hold_pc    = pc;
    hold_instr = instr;
    hold_cnt   = fetch_cnt;
    check("slow_pc", pc, 32'h0000_3008);
    repeat (4) begin
      tick(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("stall_iv", {31'd0, instr_valid}, 32'd1);
      check("stall_pc", pc, hold_pc);
      check("stall_instr", instr, hold_instr);
      check("stall_cnt", fetch_cnt, hold_cnt);
    end
    idle_tick();
    check("unstall_cnt", fetch_cnt, hold_cnt + 32'd1);

    // Branch beats jump; jump alone.
    wait_iv();
    tick(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3100, 1'b1, 32'h0000_3200);
    wait_iv();
    check("br_over_j", pc, 32'h0000_3100);
    tick(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_3200);
    wait_iv();
    check("jump_pc", pc, 32'h0000_3200);

    // Flush overtaking a pending 3-cycle request.
    idle_tick();
    tick(1'b0, 1'b1, 32'h0000_4180, 1'b0, 32'h0, 1'b0, 32'h0);
    n = 0;
    while (imem.imem_addr != 32'h0000_4180 && n < 10) begin
      idle_tick();
      n++;
    end
    check("flush_addr", imem.imem_addr, 32'h0000_4180);
    check("flush_req", {31'd0, imem.imem_req}, 32'd1);
    check("flush_no_iv", {31'd0, instr_valid}, 32'd0);
    wait_iv();
    check("flush_pc", pc, 32'h0000_4180);

    // Misaligned branch target is aligned and flagged stickily.
    tick(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3102, 1'b0, 32'h0);
    wait_iv();
    check("mis_pc", pc, 32'h0000_3100);
    check("mis_err", {31'd0, addr_err}, 32'd1);
    repeat (6) idle_tick();
    check("mis_sticky", {31'd0, addr_err}, 32'd1);
    do_reset(2);

    // Randomized traffic.
    lat_fixed = -1;
    wait_left = next_lat();
    idle_tick();
    for (int i = 0; i < 3000; i++) begin
      bit st, fl, br, jj;
      st = ($urandom_range(0, 9) < 3);
      fl = ($urandom_range(0, 99) < 6);
      br = ($urandom_range(0, 4) == 0);
      jj = ($urandom_range(0, 4) == 0);
      tick(st, fl, rand_target(), br, rand_target(), jj, rand_target());
    end

    // Reset in the middle of a wait, then a stale ack afterwards.
    lat_fixed = 3;
    wait_iv();
    idle_tick();
    wait_iv();
    idle_tick();
    idle_tick();
    check("midwait_req", {31'd0, imem.imem_req}, 32'd1);
    check("midwait_iv", {31'd0, instr_valid}, 32'd0);
    do_reset(2);
    stale = 1'b1;
    idle_tick();
    stale = 1'b0;
    check("restart_req", {31'd0, imem.imem_req}, 32'd1);
    check("restart_addr", imem.imem_addr, 32'h0000_3000);
    check("restart_iv", {31'd0, instr_valid}, 32'd0);
    wait_iv();
    check("restart_pc", pc, 32'h0000_3000);
    check("restart_instr", instr, mem_word(32'h0000_3000));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
